// File: rtl/rom_stream_reader_pkg.sv
// Shared definitions for the ROM stream reader: default geometry of the
// 128x64 ROM and the burst controller state encoding.
package rom_stream_reader_pkg;
   localparam int MEM_AW = 7;
   localparam int MEM_DW = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;
endpackage

// File: rtl/rom_stream_reader_rdbuf.sv
// Two-entry {addr,data} skid buffer between the ROM read port and the stream
// output; flush empties it in one edge without touching stored payload.
module rom_rdbuf
   import rom_stream_reader_pkg::*;
#(
   parameter int AW = MEM_AW,
   parameter int DW = MEM_DW
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          push,
   input  logic [AW-1:0] push_addr,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   input  logic          flush,
   output logic          full,
   output logic          empty,
   output logic [AW-1:0] head_addr,
   output logic [DW-1:0] head_data
);

   logic [AW-1:0] addr_mem [2];
   logic [DW-1:0] data_mem [2];
   logic          wr_ptr;
   logic          rd_ptr;
   logic [1:0]    count;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         addr_mem[0] <= '0;
         addr_mem[1] <= '0;
         data_mem[0] <= '0;
         data_mem[1] <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         count       <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign full      = (count == 2'd2);
   assign empty     = (count == 2'd0);
   assign head_addr = addr_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];

endmodule

// File: rtl/rom_stream_reader.sv
// Burst reader: issues sequential reads to a synchronous ROM and streams the
// returned words out through a valid/ready port, with abort support.
module rom_stream_reader
   import rom_stream_reader_pkg::*;
#(
   parameter int AW = MEM_AW,
   parameter int DW = MEM_DW
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          Start,
   input  logic [AW-1:0] StartAddr,
   input  logic [AW-1:0] Count,
   input  logic          Abort,
   output logic          Busy,
   output logic          Done,
   output logic          CEB,
   output logic [AW-1:0] A,
   input  logic [DW-1:0] Q,
   output logic          OutValid,
   input  logic          OutReady,
   output logic [DW-1:0] OutData,
   output logic [AW-1:0] OutAddr
);

   rd_state_t     state;
   logic [AW-1:0] issue_addr;
   logic [AW-1:0] last_a;
   logic [AW:0]   issue_left;
   logic [AW:0]   out_left;
   logic [AW:0]   burst_len;
   logic          inflight;
   logic [AW-1:0] inflight_addr;
   logic          buf_full;
   logic          buf_empty;
   logic          pop;
   logic          issue;
   logic [1:0]    pending;

   // Every read is committed a FIFO slot: buffered + in-flight + new issue
   // never exceeds two, unless a word leaves in the same cycle.
   assign pop       = !buf_empty && OutReady;
   assign pending   = {buf_full, !buf_full && !buf_empty} + {1'b0, inflight};
   assign issue     = (state == ISSUE) && !Abort &&
                      ((pending < 2'd2) || ((pending == 2'd2) && pop));
   assign burst_len = (Count == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, Count};

   assign CEB      = !issue;
   assign A        = issue ? issue_addr : last_a;
   assign Busy     = (state != IDLE);
   assign OutValid = !buf_empty;

   rom_rdbuf #(.AW(AW), .DW(DW)) u_rdbuf (
      .clk       (clk),
      .resetn    (resetn),
      .push      (inflight),
      .push_addr (inflight_addr),
      .push_data (Q),
      .pop       (pop),
      .flush     (Abort && Busy),
      .full      (buf_full),
      .empty     (buf_empty),
      .head_addr (OutAddr),
      .head_data (OutData)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         issue_addr    <= '0;
         last_a        <= '0;
         issue_left    <= '0;
         out_left      <= '0;
         inflight      <= 1'b0;
         inflight_addr <= '0;
         Done          <= 1'b0;
      end else begin
         Done     <= 1'b0;
         inflight <= issue;
         if (issue) begin
            inflight_addr <= issue_addr;
            last_a        <= issue_addr;
            issue_addr    <= issue_addr + 1'b1;
            issue_left    <= issue_left - 1'b1;
         end
         if (pop) begin
            out_left <= out_left - 1'b1;
         end
         case (state)
            IDLE: begin
               if (Start) begin
                  state      <= ISSUE;
                  issue_addr <= StartAddr;
                  issue_left <= burst_len;
                  out_left   <= burst_len;
               end
            end
            ISSUE: begin
               if (Abort) begin
                  state <= IDLE;
               end else if (issue && (issue_left == 1)) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               // Last word leaving means nothing is buffered or in flight.
               if (Abort) begin
                  state <= IDLE;
               end else if (pop && (out_left == 1)) begin
                  state <= IDLE;
                  Done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Self-checking bench for rom_stream_reader: behavioural ROM, expected-word
// scoreboard drained by a stream monitor, and one task per scenario.
module tb_rom_stream_reader;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        Start = 1'b0;
   logic [6:0]  StartAddr = '0;
   logic [6:0]  Count = '0;
   logic        Abort = 1'b0;
   logic        Busy;
   logic        Done;
   logic        CEB;
   logic [6:0]  A;
   logic [63:0] Q;
   logic        OutValid;
   logic        OutReady = 1'b0;
   logic [63:0] OutData;
   logic [6:0]  OutAddr;

   typedef struct {
      logic [6:0]  addr;
      logic [63:0] data;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   word_count = 0;
   int   done_count = 0;
   int   outstanding = 0;
   bit   prev_stall = 1'b0;
   logic [63:0] prev_data;
   logic [6:0]  prev_addr;

   rom_stream_reader dut (
      .clk       (clk),
      .resetn    (resetn),
      .Start     (Start),
      .StartAddr (StartAddr),
      .Count     (Count),
      .Abort     (Abort),
      .Busy      (Busy),
      .Done      (Done),
      .CEB       (CEB),
      .A         (A),
      .Q         (Q),
      .OutValid  (OutValid),
      .OutReady  (OutReady),
      .OutData   (OutData),
      .OutAddr   (OutAddr)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] rom_word(input logic [6:0] a);
      return 64'h0123_4567_89AB_CDEF ^ ({57'd0, a} * 64'h9E37_79B9_7F4A_7C15);
   endfunction

   always @(posedge clk) begin
      if (!CEB) Q <= rom_word(A);
   end

   // Stream monitor: scoreboard compare, stall stability and issue gating.
   always @(negedge clk) begin
      bit   popped;
      exp_t e;
      if (!resetn) begin
         sb.delete();
         outstanding = 0;
         prev_stall  = 1'b0;
      end else begin
         popped = OutValid && OutReady;
         if (!CEB) begin
            checks++;
            if (outstanding >= 2 && !popped) begin
               errors++;
               $display("[TB] FAIL issue_gate: CEB=%b with outstanding=%0d and no pop", CEB, outstanding);
            end
         end
         if (prev_stall) begin
            checks++;
            if (OutValid !== 1'b1 || OutData !== prev_data || OutAddr !== prev_addr) begin
               errors++;
               $display("[TB] FAIL stall_stable: got v=%b a=%h d=%h, need v=1 a=%h d=%h",
                        OutValid, OutAddr, OutData, prev_addr, prev_data);
            end
         end
         if (popped) begin
            word_count++;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_word: got addr %h, none expected", OutAddr);
            end else begin
               e = sb.pop_front();
               if (OutAddr !== e.addr || OutData !== e.data) begin
                  errors++;
                  $display("[TB] FAIL word: got a=%h d=%h, need a=%h d=%h", OutAddr, OutData, e.addr, e.data);
               end
            end
         end
         if (Done) done_count++;
         if (!CEB) outstanding++;
         if (popped) outstanding--;
         prev_stall = OutValid && !OutReady;
         prev_data  = OutData;
         prev_addr  = OutAddr;
         if (Abort && Busy) begin
            sb.delete();
            outstanding = 0;
            prev_stall  = 1'b0;
         end
      end
   end

   task automatic expect_burst(input logic [6:0] start, input int n);
      for (int i = 0; i < n; i++) begin
         logic [6:0] a;
         a = start + 7'(i);
         sb.push_back('{addr: a, data: rom_word(a)});
      end
   endtask

   // Start lands in cycle 0; returns 1ns into cycle 1 with Start dropped.
   task automatic applyStimulus(input logic [6:0] addr, input logic [6:0] cnt);
      @(posedge clk); #1;
      Start = 1'b1; StartAddr = addr; Count = cnt;
      @(posedge clk); #1;
      Start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (sb.size() == 0 && !Busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #1 resetn = 1'b0;
      #2;
      checks++;
      if ({CEB, A, Busy, Done, OutValid, OutData, OutAddr} !== {1'b1, 7'd0, 1'b0, 1'b0, 1'b0, 64'd0, 7'd0}) begin
         errors++;
         $display("[TB] FAIL reset_values: got ceb=%b a=%h busy=%b done=%b v=%b d=%h oa=%h, need 1/0/0/0/0/0/0",
                  CEB, A, Busy, Done, OutValid, OutData, OutAddr);
      end
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   task automatic test_basic();
      int before_d;
      before_d = done_count;
      OutReady = 1'b1;
      expect_burst(7'h10, 4);
      applyStimulus(7'h10, 7'd4);
      @(negedge clk);
      checks++;
      if (CEB !== 1'b0 || A !== 7'h10 || Busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL first_issue: got ceb=%b a=%h busy=%b, need 0/10/1", CEB, A, Busy);
      end
      @(negedge clk);
      checks++;
      if (OutValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL latency_c2: got OutValid=%b, need 0", OutValid);
      end
      for (int c = 3; c <= 6; c++) begin
         @(negedge clk);
         checks++;
         if (OutValid !== 1'b1 || OutAddr !== 7'(16 + c - 3)) begin
            errors++;
            $display("[TB] FAIL stream_c%0d: got v=%b a=%h, need v=1 a=%h", c, OutValid, OutAddr, 7'(16 + c - 3));
         end
      end
      @(negedge clk);
      checks++;
      if (Done !== 1'b1 || Busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL done_c7: got done=%b busy=%b, need 1/0", Done, Busy);
      end
      @(negedge clk);
      checks++;
      if (Done !== 1'b0 || done_count != before_d + 1) begin
         errors++;
         $display("[TB] FAIL done_once: got done=%b pulses=%0d, need 0/1", Done, done_count - before_d);
      end
   endtask

   task automatic test_wrap();
      int before_d, before_w;
      bit ok;
      before_d = done_count;
      before_w = word_count;
      OutReady = 1'b1;
      expect_burst(7'h7E, 3);
      applyStimulus(7'h7E, 7'd3);
      wait_idle(40, ok);
      @(negedge clk);
      checks++;
      if (!ok || word_count - before_w != 3 || done_count - before_d != 1) begin
         errors++;
         $display("[TB] FAIL wrap: got idle=%b words=%0d done=%0d, need 1/3/1", ok, word_count - before_w, done_count - before_d);
      end
   endtask

   task automatic test_full_burst();
      int before_d, n;
      logic done_at, v_c2;
      before_d = done_count;
      n = 0;
      done_at = 1'b0;
      v_c2 = 1'b1;
      OutReady = 1'b1;
      expect_burst(7'h00, 128);
      applyStimulus(7'h00, 7'd0);
      for (int c = 1; c <= 131; c++) begin
         @(negedge clk);
         if (c == 2) v_c2 = OutValid;
         if (c >= 3 && c <= 130 && OutValid && OutReady) n++;
         if (c == 131) done_at = Done;
      end
      @(negedge clk);
      checks++;
      if (v_c2 !== 1'b0 || n != 128) begin
         errors++;
         $display("[TB] FAIL full_rate: got v_c2=%b words=%0d, need 0/128", v_c2, n);
      end
      checks++;
      if (done_at !== 1'b1 || done_count - before_d != 1 || sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL full_done: got done=%b pulses=%0d left=%0d, need 1/1/0", done_at, done_count - before_d, sb.size());
      end
   endtask

   task automatic test_stall();
      int before_d, before_w;
      bit ok;
      before_d = done_count;
      before_w = word_count;
      OutReady = 1'b0;
      expect_burst(7'h30, 8);
      applyStimulus(7'h30, 7'd8);
      ok = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(posedge clk); #1;
         OutReady = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (sb.size() == 0 && !Busy) begin
            ok = 1'b1;
            break;
         end
      end
      OutReady = 1'b1;
      @(negedge clk);
      checks++;
      if (!ok || word_count - before_w != 8 || done_count - before_d != 1) begin
         errors++;
         $display("[TB] FAIL stall_burst: got idle=%b words=%0d done=%0d, need 1/8/1", ok, word_count - before_w, done_count - before_d);
      end
   endtask

   task automatic test_abort();
      int before_d, before_w;
      bit ok;
      before_d = done_count;
      before_w = word_count;
      OutReady = 1'b1;
      expect_burst(7'h40, 16);
      applyStimulus(7'h40, 7'd16);
      repeat (6) @(posedge clk);
      #1 Abort = 1'b1;
      @(negedge clk);
      checks++;
      if (OutValid !== 1'b1 || OutAddr !== 7'h44) begin
         errors++;
         $display("[TB] FAIL abort_fifth: got v=%b a=%h, need 1/44", OutValid, OutAddr);
      end
      @(posedge clk); #1;
      Abort = 1'b0;
      @(negedge clk);
      checks++;
      if (OutValid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_next: got v=%b busy=%b done=%b, need 0/0/0", OutValid, Busy, Done);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (done_count != before_d || word_count - before_w != 5 || OutValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_quiet: got done=%0d words=%0d v=%b, need 0/5/0", done_count - before_d, word_count - before_w, OutValid);
      end
      expect_burst(7'h05, 2);
      applyStimulus(7'h05, 7'd2);
      wait_idle(40, ok);
      @(negedge clk);
      checks++;
      if (!ok || done_count - before_d != 1 || word_count - before_w != 7) begin
         errors++;
         $display("[TB] FAIL abort_restart: got idle=%b done=%0d words=%0d, need 1/1/7", ok, done_count - before_d, word_count - before_w);
      end
   endtask

   task automatic test_reset_mid();
      int bad;
      OutReady = 1'b1;
      expect_burst(7'h20, 16);
      applyStimulus(7'h20, 7'd16);
      repeat (4) @(posedge clk);
      #1 resetn = 1'b0;
      #1;
      checks++;
      if ({CEB, A, Busy, Done, OutValid, OutData, OutAddr} !== {1'b1, 7'd0, 1'b0, 1'b0, 1'b0, 64'd0, 7'd0}) begin
         errors++;
         $display("[TB] FAIL reset_mid: got ceb=%b a=%h busy=%b done=%b v=%b d=%h oa=%h, need 1/0/0/0/0/0/0",
                  CEB, A, Busy, Done, OutValid, OutData, OutAddr);
      end
      @(posedge clk); #1;
      resetn = 1'b1;
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (OutValid !== 1'b0 || CEB !== 1'b1 || Busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL reset_release: got %0d active cycles, need 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_full_burst();
      test_stall();
      test_abort();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, need completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/rom_stream_reader.md
ROM_STREAM_READER -- requirements
Module: rom_stream_reader

Interface
REQ-001 SHALL have parameter AW, default 7, ROM address width.
REQ-002 SHALL have parameter DW, default 64, ROM data width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port Start, input, 1, request a burst; sampled only when Busy=0.
REQ-006 SHALL have port StartAddr, input, AW, first word address of the burst.
REQ-007 SHALL have port Count, input, AW, burst length in words; 0 means 2^AW (128).
REQ-008 SHALL have port Abort, input, 1, cancel the active burst.
REQ-009 SHALL have port Busy, output, 1, burst in progress.
REQ-010 SHALL have port Done, output, 1, one-cycle pulse on normal burst completion.
REQ-011 SHALL have port CEB, output, 1, ROM chip enable, active-low.
REQ-012 SHALL have port A, output, AW, ROM address.
REQ-013 SHALL have port Q, input, DW, ROM read data; valid the cycle after the edge that sampled CEB=0.
REQ-014 SHALL have port OutValid, output, 1, stream word valid.
REQ-015 SHALL have port OutReady, input, 1, consumer accepts the word.
REQ-016 SHALL have port OutData, output, DW, stream data.
REQ-017 SHALL have port OutAddr, output, AW, ROM address of OutData.

Function
REQ-018 SHALL use states IDLE, ISSUE, DRAIN; IDLE->ISSUE on Start; ISSUE->DRAIN when the last read issues; DRAIN->IDLE when the buffer is empty and nothing is in flight.
REQ-019 SHALL ignore Start while Busy=1; Busy=1 in ISSUE and DRAIN only.
REQ-020 SHALL issue a read (CEB=0, A=issue address) only when buffer occupancy + in-flight reads < 2, or when that sum is 2 and a word is popped in the same cycle.
REQ-021 SHALL increment the issue address mod 2^AW after each issue (127 wraps to 0).
REQ-022 SHALL capture Q with its address into a 2-entry FIFO on the edge ending the cycle after issue.
REQ-023 SHALL present the FIFO head on OutData/OutAddr with OutValid; transfer occurs when OutValid and OutReady are both 1.
REQ-024 SHALL hold OutData/OutAddr/OutValid stable while OutValid=1 and OutReady=0.
REQ-025 SHALL achieve the following timing: Start in cycle 0 -> CEB=0 in cycle 1 -> OutValid=1 in cycle 3; with OutReady held at 1, one word per cycle thereafter.
REQ-026 SHALL deliver exactly Count words (128 for Count=0) in ascending wrapped address order.
REQ-027 SHALL pulse Done in the cycle after the last word transfers, with Busy=0 in that same cycle.
REQ-028 SHALL, on Abort with Busy=1, stop issuing, discard FIFO contents and in-flight data, drive OutValid=0 next cycle, return to IDLE, and not pulse Done.
REQ-029 SHALL ignore Abort while Busy=0; when Abort and Start coincide in IDLE, Start wins.
REQ-030 SHALL drive CEB=1 in IDLE and DRAIN; A holds its last value when CEB=1.

Reset
REQ-031 SHALL, on resetn=0, immediately force CEB=1, A=0, Busy=0, Done=0, OutValid=0, OutData=0, OutAddr=0, state IDLE, FIFO empty, in-flight count 0.
REQ-032 SHALL discard all in-flight and buffered data on reset mid-burst; no word is emitted after reset releases without a new Start.

Structure
REQ-033 SHALL place AW/DW defaults and the state enum typedef in the shared mem package.
REQ-034 SHALL implement the 2-entry {addr,data} buffer as sub-module rom_rdbuf with push, pop, flush, full, empty.
REQ-035 SHALL connect CEB/A/Q directly to the 128x64 ROM wrapper with no added combinational logic on Q.

Verification
REQ-036 Start, StartAddr=0x10, Count=4, OutReady=1 -> words from addresses 0x10..0x13 in cycles 3..6; Done pulse in cycle 7.
REQ-037 StartAddr=0x7E, Count=3 -> OutAddr sequence 0x7E, 0x7F, 0x00.
REQ-038 Count=0, OutReady=1 -> 128 words, addresses 0..127 from StartAddr=0, one per cycle; exactly one Done.
REQ-039 Count=8, OutReady toggling 1/0 pseudo-randomly -> no word lost or duplicated, OutData stable while stalled, CEB=0 never with occupancy+in-flight=2 and no pop.
REQ-040 Count=16, Abort at the 5th transfer -> OutValid=0 next cycle, Busy=0, no Done; a following Start/Count=2 returns correct data.
REQ-041 resetn=0 asserted mid-burst -> all outputs at reset values immediately; no OutValid after release until the next Start.
